// File: rtl/uart_tx.sv
// UART transmitter: 8-entry write FIFO feeding an 8N1, LSB-first serialiser.
// The baud period is DIV_CNT+1 clocks, and frames queued in the FIFO go out back-to-back.
module uart_tx #(
  parameter int                 DIV_WID = 10,
  parameter logic [DIV_WID-1:0] DIV_CNT = 10'd520,
  parameter int                 FIFO_AW = 3
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_data,
  input  logic       i_dataen,
  output logic       o_full,
  output logic       o_empty,
  output logic       o_overflow,
  output logic       o_busy,
  output logic       o_uart_tx
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wptr_q, rptr_q;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               full_q, empty_q, ovf_q;
  logic               push, pop;

  state_t             state_q, state_d;
  logic [DIV_WID-1:0] div_q, div_d;
  logic [2:0]         bitcnt_q, bitcnt_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
  logic               div_zero;

  // The full flag is the registered one, so a pop on the same edge cannot rescue a write.
  assign push     = i_dataen & ~full_q;
  assign div_zero = (div_q == '0);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (FIFO_AW+1)'(1);
      2'b01:   count_d = count_q - (FIFO_AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wptr_q] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + FIFO_AW'(1);
      if (pop)  rptr_q <= rptr_q + FIFO_AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == FULL_CNT);
      empty_q <= (count_d == '0);
      ovf_q   <= i_dataen & full_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
    pop      = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (!empty_q) begin
          pop     = 1'b1;
          shift_d = mem_q[rptr_q];
          div_d   = DIV_CNT;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (div_zero) begin
          div_d    = DIV_CNT;
          tx_d     = shift_q[0];
          bitcnt_d = '0;
          state_d  = S_DATA;
        end else begin
          div_d = div_q - DIV_WID'(1);
        end
      end
      S_DATA: begin
        if (div_zero) begin
          div_d = DIV_CNT;
          if (bitcnt_q != 3'd7) begin
            shift_d  = {1'b0, shift_q[7:1]};
            tx_d     = shift_q[1];
            bitcnt_d = bitcnt_q + 3'd1;
          end else begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end
        end else begin
          div_d = div_q - DIV_WID'(1);
        end
      end
      S_STOP: begin
        // Chain straight into the next start bit when more data is queued.
        if (div_zero) begin
          if (!empty_q) begin
            pop     = 1'b1;
            shift_d = mem_q[rptr_q];
            div_d   = DIV_CNT;
            tx_d    = 1'b0;
            state_d = S_START;
          end else begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end else begin
          div_d = div_q - DIV_WID'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_full     = full_q;
  assign o_empty    = empty_q;
  assign o_overflow = ovf_q;
  assign o_busy     = busy_q;
  assign o_uart_tx  = tx_q;

endmodule
